// File: rtl/lru_cache_ctrl.sv
// Fully-associative line cache with true-LRU replacement in front of a
// multi-beat backend read port. Only one lookup is outstanding at a time.
module lru_cache_ctrl #(
  parameter int TAGS_WIDTH  = 48,
  parameter int LINE_WIDTH  = 512,
  parameter int BEAT_WIDTH  = 128,
  parameter int CACHE_DEPTH = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fe_req_tvalid,
  output logic                  fe_req_tready,
  input  logic [TAGS_WIDTH-1:0] fe_req_tdata,
  output logic                  fe_rsp_tvalid,
  input  logic                  fe_rsp_tready,
  output logic [LINE_WIDTH-1:0] fe_rsp_tdata,
  output logic                  fe_rsp_tuser,
  output logic                  be_req_tvalid,
  input  logic                  be_req_tready,
  output logic [TAGS_WIDTH-1:0] be_req_tdata,
  input  logic                  be_rsp_tvalid,
  output logic                  be_rsp_tready,
  input  logic [BEAT_WIDTH-1:0] be_rsp_tdata,
  input  logic                  be_rsp_tlast,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic                  err
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int AW    = $clog2(CACHE_DEPTH);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [AW-1:0]  OLDEST    = AW'(CACHE_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, BREQ, FILL, RSP} state_t;

  state_t state_reg, state_next;

  logic [TAGS_WIDTH-1:0]  tag_mem  [CACHE_DEPTH];
  logic [LINE_WIDTH-1:0]  line_mem [CACHE_DEPTH];
  logic [AW-1:0]          age_reg  [CACHE_DEPTH];
  logic [CACHE_DEPTH-1:0] valid_reg;

  logic                   flush_pend_reg;
  logic [TAGS_WIDTH-1:0]  req_tag_reg;
  logic [BCW-1:0]         beat_cnt_reg;
  logic [LINE_WIDTH-1:0]  fill_buf_reg;
  logic [LINE_WIDTH-1:0]  rsp_data_reg;
  logic                   rsp_user_reg;
  logic [CNT_WIDTH-1:0]   hit_cnt_reg;
  logic [CNT_WIDTH-1:0]   miss_cnt_reg;
  logic                   err_reg;

  logic [CACHE_DEPTH-1:0] hit_vec;
  logic                   hit_any;
  logic [AW-1:0]          hit_idx;
  logic [AW-1:0]          victim_idx;
  logic [AW-1:0]          touch_idx;
  logic                   touch_en;
  logic                   flush_now;
  logic                   req_acc;
  logic                   beat_acc;
  logic                   last_beat;
  logic                   fill_done;
  logic [LINE_WIDTH-1:0]  fill_line;

  // A flush seen outside IDLE waits here and wins over the next accept.
  assign flush_now = (state_reg == IDLE) && (flush || flush_pend_reg);
  assign req_acc   = fe_req_tvalid && fe_req_tready;
  assign beat_acc  = (state_reg == FILL) && be_rsp_tvalid;
  assign last_beat = (beat_cnt_reg == LAST_BEAT);
  assign fill_done = beat_acc && last_beat;

  generate
    for (genvar gi = 0; gi < CACHE_DEPTH; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_reg[gi] && (tag_mem[gi] == fe_req_tdata);
    end
  endgenerate

  assign hit_any = |hit_vec;

  always_comb begin
    hit_idx = '0;
    for (int i = CACHE_DEPTH - 1; i >= 0; i--)
      if (hit_vec[i]) hit_idx = AW'(i);
  end

  // Lowest free line first; otherwise the line whose age says least recent.
  always_comb begin
    victim_idx = '0;
    for (int i = 0; i < CACHE_DEPTH; i++)
      if (age_reg[i] == OLDEST) victim_idx = AW'(i);
    for (int i = CACHE_DEPTH - 1; i >= 0; i--)
      if (!valid_reg[i]) victim_idx = AW'(i);
  end

  assign touch_en  = (req_acc && hit_any) || fill_done;
  assign touch_idx = fill_done ? victim_idx : hit_idx;

  always_comb begin
    fill_line = fill_buf_reg;
    for (int k = 0; k < BEATS; k++)
      if (beat_cnt_reg == BCW'(k)) fill_line[k*BEAT_WIDTH +: BEAT_WIDTH] = be_rsp_tdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_acc) state_next = hit_any ? RSP : BREQ;
      BREQ: if (be_req_tready) state_next = FILL;
      FILL: if (fill_done) state_next = RSP;
      RSP:  if (fe_rsp_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fe_req_tready = (state_reg == IDLE) && !flush_now;
    be_req_tvalid = (state_reg == BREQ);
    be_rsp_tready = (state_reg == FILL);
    fe_rsp_tvalid = (state_reg == RSP);
  end

  // Line storage carries no reset; valid_reg guards every read.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      line_mem[victim_idx] <= fill_line;
      tag_mem[victim_idx]  <= req_tag_reg;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg <= '0;
      for (int i = 0; i < CACHE_DEPTH; i++) age_reg[i] <= AW'(i);
      flush_pend_reg <= 1'b0;
      req_tag_reg    <= '0;
      beat_cnt_reg   <= '0;
      fill_buf_reg   <= '0;
      rsp_data_reg   <= '0;
      rsp_user_reg   <= 1'b0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (state_reg != IDLE) begin
        if (flush) flush_pend_reg <= 1'b1;
      end else if (flush_now) begin
        valid_reg      <= '0;
        flush_pend_reg <= 1'b0;
      end
      if (fill_done) valid_reg[victim_idx] <= 1'b1;

      if (touch_en) begin
        for (int i = 0; i < CACHE_DEPTH; i++) begin
          if (AW'(i) == touch_idx)              age_reg[i] <= '0;
          else if (age_reg[i] < age_reg[touch_idx]) age_reg[i] <= age_reg[i] + 1'b1;
        end
      end

      if (req_acc) begin
        if (hit_any) begin
          rsp_data_reg <= line_mem[hit_idx];
          rsp_user_reg <= 1'b1;
          if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + 1'b1;
        end else begin
          req_tag_reg <= fe_req_tdata;
          if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + 1'b1;
        end
      end

      // Completion follows the beat count; tlast is only checked.
      if (beat_acc) begin
        fill_buf_reg <= fill_line;
        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
        if (be_rsp_tlast != last_beat) err_reg <= 1'b1;
      end
      if (fill_done) begin
        rsp_data_reg <= fill_line;
        rsp_user_reg <= 1'b0;
      end
    end
  end

  assign fe_rsp_tdata = rsp_data_reg;
  assign fe_rsp_tuser = rsp_user_reg;
  assign be_req_tdata = req_tag_reg;
  assign hit_cnt      = hit_cnt_reg;
  assign miss_cnt     = miss_cnt_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_lru_cache_ctrl.sv
// Bench for lru_cache_ctrl: directed table, corner sequences and random
// traffic against a recency-list model of the cache.
module tb_lru_cache_ctrl;

  localparam int TW = 48;
  localparam int LW = 512;
  localparam int BW = 128;
  localparam int DEPTH = 4;
  localparam int CW = 5;
  localparam int BEATS = LW / BW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rstn;
  logic          fe_req_tvalid, fe_req_tready;
  logic [TW-1:0] fe_req_tdata;
  logic          fe_rsp_tvalid, fe_rsp_tready;
  logic [LW-1:0] fe_rsp_tdata;
  logic          fe_rsp_tuser;
  logic          be_req_tvalid, be_req_tready;
  logic [TW-1:0] be_req_tdata;
  logic          be_rsp_tvalid, be_rsp_tready;
  logic [BW-1:0] be_rsp_tdata;
  logic          be_rsp_tlast;
  logic          flush;
  logic [CW-1:0] hit_cnt, miss_cnt;
  logic          err;

  lru_cache_ctrl #(
    .TAGS_WIDTH(TW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW),
    .CACHE_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .fe_req_tvalid(fe_req_tvalid), .fe_req_tready(fe_req_tready), .fe_req_tdata(fe_req_tdata),
    .fe_rsp_tvalid(fe_rsp_tvalid), .fe_rsp_tready(fe_rsp_tready), .fe_rsp_tdata(fe_rsp_tdata),
    .fe_rsp_tuser(fe_rsp_tuser),
    .be_req_tvalid(be_req_tvalid), .be_req_tready(be_req_tready), .be_req_tdata(be_req_tdata),
    .be_rsp_tvalid(be_rsp_tvalid), .be_rsp_tready(be_rsp_tready), .be_rsp_tdata(be_rsp_tdata),
    .be_rsp_tlast(be_rsp_tlast),
    .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model: line contents plus a recency list (front = most recent)
  logic [TW-1:0] m_tag   [DEPTH];
  bit            m_valid [DEPTH];
  logic [LW-1:0] m_data  [DEPTH];
  int            m_rec[$];
  int            m_hits, m_misses, m_seq;
  bit            m_err;

  // backend responder state
  bit            bk_busy;
  logic [TW-1:0] bk_tag, bk_last_tag;
  int            bk_seq, bk_idx, bk_reqs;
  bit            bad_tlast;
  bit            fe_req_hs;

  typedef struct {
    bit            do_flush;
    logic [TW-1:0] tag;
    bit            exp_hit;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [BW-1:0] beat_val(input logic [TW-1:0] tag, input int seq, input int j);
    if (tag == 48'h100 && seq == 0) return 128'hA0 + 128'(j);
    return {16'hC0DE, tag, 32'(seq), 32'(j)};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    m_rec = {0, 1, 2, 3};
    m_hits = 0;
    m_misses = 0;
    m_err = 0;
  endfunction

  function automatic void model_touch(input int l);
    for (int i = 0; i < m_rec.size(); i++)
      if (m_rec[i] == l) begin
        m_rec.delete(i);
        break;
      end
    m_rec.push_front(l);
  endfunction

  function automatic int model_victim();
    for (int i = 0; i < DEPTH; i++)
      if (!m_valid[i]) return i;
    return m_rec[$];
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
  endfunction

  // One clock: drive backend at negedge, note handshakes, advance to next negedge.
  task automatic step();
    bit rsp_beat;
    be_req_tready = ($urandom_range(0, 3) != 0);
    if (bk_busy) begin
      be_rsp_tvalid = ($urandom_range(0, 3) != 0);
      be_rsp_tdata  = beat_val(bk_tag, bk_seq, bk_idx);
      be_rsp_tlast  = bad_tlast ? (bk_idx == 1) : (bk_idx == BEATS - 1);
    end else begin
      be_rsp_tvalid = 1'b0;
      be_rsp_tdata  = '0;
      be_rsp_tlast  = 1'b0;
    end
    #1;
    fe_req_hs = fe_req_tvalid && fe_req_tready;
    rsp_beat  = be_rsp_tvalid && be_rsp_tready;
    if (rsp_beat) begin
      bk_idx++;
      if (bk_idx == BEATS) bk_busy = 0;
    end else if (be_req_tvalid && be_req_tready) begin
      bk_busy = 1;
      bk_tag = be_req_tdata;
      bk_last_tag = be_req_tdata;
      bk_seq = bk_reqs;
      bk_reqs++;
      bk_idx = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush(input string lbl);
    flush = 1'b1;
    #1;
    chk({lbl, "_flush_rdy"}, 512'(fe_req_tready), 512'(0));
    step();
    flush = 1'b0;
    model_flush();
    $display("flush %s", lbl);
  endtask

  task automatic run_req(input logic [TW-1:0] tag, input int stall, input bit flush_mid,
                         input bit has_exp, input bit exp_hit, input string lbl,
                         output logic [LW-1:0] got);
    bit            m_hit, flushed;
    int            m_line, n, lat, reqs0;
    logic [LW-1:0] exp_data, d0;
    logic          u0;
    got = '0;
    m_hit = 0;
    m_line = 0;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_tag[i] == tag) begin
        m_hit = 1;
        m_line = i;
      end
    if (m_hit) begin
      exp_data = m_data[m_line];
      m_hits = (m_hits == CMAX) ? CMAX : m_hits + 1;
    end else begin
      m_line = model_victim();
      for (int j = 0; j < BEATS; j++) exp_data[j*BW +: BW] = beat_val(tag, m_seq, j);
      m_seq++;
      m_tag[m_line] = tag;
      m_valid[m_line] = 1;
      m_data[m_line] = exp_data;
      m_misses = (m_misses == CMAX) ? CMAX : m_misses + 1;
    end
    model_touch(m_line);
    if (flush_mid && !m_hit) model_flush();

    reqs0 = bk_reqs;
    fe_req_tvalid = 1'b1;
    fe_req_tdata  = tag;
    n = 0;
    do begin
      step();
      n++;
    end while (!fe_req_hs && n < 60);
    fe_req_tvalid = 1'b0;
    if (!fe_req_hs) begin
      timeout({lbl, "_accept"});
      return;
    end

    lat = 1;
    flushed = 0;
    while (!fe_rsp_tvalid && lat < 200) begin
      if (flush_mid && !flushed && be_rsp_tready) begin
        flush = 1'b1;
        flushed = 1;
      end
      step();
      flush = 1'b0;
      lat++;
    end
    if (!fe_rsp_tvalid) begin
      timeout({lbl, "_rsp"});
      return;
    end
    if (m_hit) chk({lbl, "_hit_lat"}, 512'(lat), 512'(1));

    d0 = fe_rsp_tdata;
    u0 = fe_rsp_tuser;
    for (int s = 0; s < stall; s++) begin
      chk({lbl, "_stall_req_rdy"}, 512'(fe_req_tready), 512'(0));
      step();
      chk({lbl, "_stall_valid"}, 512'(fe_rsp_tvalid), 512'(1));
      chk({lbl, "_stall_data"}, fe_rsp_tdata, d0);
      chk({lbl, "_stall_user"}, 512'(fe_rsp_tuser), 512'(u0));
    end
    fe_rsp_tready = 1'b1;
    step();
    fe_rsp_tready = 1'b0;
    got = d0;

    chk({lbl, "_rsp_drop"}, 512'(fe_rsp_tvalid), 512'(0));
    chk({lbl, "_tuser"}, 512'(u0), 512'(m_hit));
    if (has_exp) chk({lbl, "_tuser_tbl"}, 512'(u0), 512'(exp_hit));
    chk({lbl, "_data"}, d0, exp_data);
    chk({lbl, "_be_reqs"}, 512'(bk_reqs - reqs0), 512'(m_hit ? 0 : 1));
    if (!m_hit) chk({lbl, "_be_tag"}, 512'(bk_last_tag), 512'(tag));
    chk({lbl, "_hit_cnt"}, 512'(hit_cnt), 512'(m_hits));
    chk({lbl, "_miss_cnt"}, 512'(miss_cnt), 512'(m_misses));
    chk({lbl, "_err"}, 512'(err), 512'(m_err));
    $display("req %s tag=%0h hit=%0d lat=%0d hits=%0d misses=%0d", lbl, tag, u0, lat, hit_cnt, miss_cnt);
  endtask

  task automatic check_reset(input string lbl);
    chk({lbl, "_ctrl"}, 512'({fe_req_tready, fe_rsp_tvalid, fe_rsp_tuser, be_req_tvalid, be_rsp_tready, err}),
        512'(6'b100000));
    chk({lbl, "_rsp_data"}, fe_rsp_tdata, '0);
    chk({lbl, "_be_tag"}, 512'(be_req_tdata), 512'(0));
    chk({lbl, "_cnts"}, 512'({hit_cnt, miss_cnt}), 512'(0));
  endtask

  initial begin
    logic [LW-1:0] d;
    logic [LW-1:0] cold_exp;
    int            n;

    vecs[0]  = '{1'b1, 48'd1, 1'b0};
    vecs[1]  = '{1'b0, 48'd2, 1'b0};
    vecs[2]  = '{1'b0, 48'd3, 1'b0};
    vecs[3]  = '{1'b0, 48'd4, 1'b0};
    vecs[4]  = '{1'b0, 48'd1, 1'b1};
    vecs[5]  = '{1'b0, 48'd5, 1'b0};
    vecs[6]  = '{1'b0, 48'd2, 1'b0};
    vecs[7]  = '{1'b0, 48'd1, 1'b1};
    vecs[8]  = '{1'b0, 48'd4, 1'b1};
    vecs[9]  = '{1'b0, 48'd3, 1'b0};
    vecs[10] = '{1'b1, 48'd1, 1'b0};
    vecs[11] = '{1'b0, 48'd2, 1'b0};
    vecs[12] = '{1'b0, 48'd4, 1'b0};
    vecs[13] = '{1'b0, 48'd5, 1'b0};
    vecs[14] = '{1'b0, 48'd1, 1'b1};
    vecs[15] = '{1'b0, 48'd2, 1'b1};
    vecs[16] = '{1'b0, 48'd4, 1'b1};
    vecs[17] = '{1'b0, 48'd5, 1'b1};

    rstn = 1'b0;
    fe_req_tvalid = 1'b0;
    fe_req_tdata = '0;
    fe_rsp_tready = 1'b0;
    be_req_tready = 1'b0;
    be_rsp_tvalid = 1'b0;
    be_rsp_tdata = '0;
    be_rsp_tlast = 1'b0;
    flush = 1'b0;
    bk_busy = 0;
    bk_reqs = 0;
    bk_idx = 0;
    bk_seq = 0;
    bk_tag = '0;
    bk_last_tag = '0;
    bad_tlast = 0;
    fe_req_hs = 0;
    m_seq = 0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    rstn = 1'b1;
    #1;
    check_reset("rst_release");
    @(negedge clk);

    // cold miss then hit of the same tag
    cold_exp = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
    run_req(48'h100, 0, 0, 1, 0, "cold", d);
    chk("cold_beats", d, cold_exp);
    run_req(48'h100, 0, 0, 1, 1, "rehit", d);
    chk("rehit_beats", d, cold_exp);

    // fill / reuse / evict / flush table
    for (int v = 0; v < 18; v++) begin
      if (vecs[v].do_flush) do_flush($sformatf("tbl%0d", v));
      run_req(vecs[v].tag, 0, 0, 1, vecs[v].exp_hit, $sformatf("tbl%0d", v), d);
    end

    // flush while a fill is in flight: data delivered, line then gone
    run_req(48'h200, 0, 1, 1, 0, "flush_fill", d);
    run_req(48'h200, 0, 0, 1, 0, "after_flush", d);

    // response backpressure
    run_req(48'h200, 5, 0, 1, 1, "bp", d);

    // early tlast: err sticky, fill still needs all beats
    bad_tlast = 1;
    m_err = 1;
    run_req(48'h300, 0, 0, 1, 0, "bad_tlast", d);
    bad_tlast = 0;
    run_req(48'h300, 0, 0, 1, 1, "err_sticky", d);

    // asynchronous reset in the middle of a fill
    fe_req_tvalid = 1'b1;
    fe_req_tdata = 48'h777;
    n = 0;
    do begin
      step();
      n++;
    end while (!fe_req_hs && n < 60);
    fe_req_tvalid = 1'b0;
    m_seq++;
    n = 0;
    while (!(be_rsp_tready && bk_idx >= 1) && n < 200) begin
      step();
      n++;
    end
    if (!(be_rsp_tready && bk_idx >= 1)) timeout("midfill_reach");
    #2;
    rstn = 1'b0;
    #1;
    check_reset("rst_midfill");
    bk_busy = 0;
    be_rsp_tvalid = 1'b1;
    be_rsp_tlast = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_no_beat_accept", 512'(be_rsp_tready), 512'(0));
    be_rsp_tvalid = 1'b0;
    rstn = 1'b1;
    model_reset();
    #1;
    check_reset("rst_midfill_release");
    @(negedge clk);

    // random traffic over a small tag pool; counters saturate on the way
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) do_flush($sformatf("rnd%0d", t));
      run_req(48'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 0, 0, 0,
              $sformatf("rnd%0d", t), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lru_cache_ctrl.md
Name: lru_cache_ctrl

Overview:
- Parametrised, fully-associative LRU line cache sitting between a frontend lookup stream and a backend memory-read stream in the 250 MHz box.
- Generalises the earlier fixed 8-entry LRU way: any depth, any line/beat ratio, per-line valid bits, flush, true-LRU age counters, tlast checking and hit/miss statistics.
- Returns one full line per accepted tag request, either from cache (hit) or after a multi-beat backend fill (miss).

Parameters:
- TAGS_WIDTH, 48, request tag/address width
- LINE_WIDTH, 512, cache line width
- BEAT_WIDTH, 128, backend data beat width; BEATS = LINE_WIDTH/BEAT_WIDTH, integer >= 1
- CACHE_DEPTH, 8, number of lines, >= 2
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- fe_req_tvalid / fe_req_tready / fe_req_tdata  in / out / in  1 / 1 / TAGS_WIDTH  frontend lookup request
- fe_rsp_tvalid / fe_rsp_tready / fe_rsp_tdata  out / in / out  1 / 1 / LINE_WIDTH  frontend line response
- fe_rsp_tuser  out  1  1 = hit, 0 = filled on miss
- be_req_tvalid / be_req_tready / be_req_tdata  out / in / out  1 / 1 / TAGS_WIDTH  backend line request
- be_rsp_tvalid / be_rsp_tready / be_rsp_tdata / be_rsp_tlast  in / out / in / in  1 / 1 / BEAT_WIDTH / 1  backend fill beats
- flush  in  1  invalidate all lines
- hit_cnt, miss_cnt  out  CNT_WIDTH  saturating statistics
- err  out  1  sticky tlast-mismatch flag

Behaviour:
- Clock and reset: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values:
  - state IDLE; all valid = 0; age[i] = i.
  - fe_req_tready = 1; all other outputs 0.
  - hit_cnt = miss_cnt = 0; err = 0.
- Handshake: a transfer occurs on a cycle where tvalid & tready = 1. Outputs hold tdata stable while tvalid = 1 and not yet accepted.
- IDLE state:
  - fe_req_tready = 1 unless a flush is applied this cycle.
  - On accept, compare fe_req_tdata combinationally against all lines where valid = 1.
  - Hit: copy line data to the response register, set fe_rsp_tuser = 1, touch the line, hit_cnt++, go to RSP. fe_rsp_tvalid is asserted the cycle after accept (latency 1).
  - Miss: latch the tag, miss_cnt++, go to BREQ.
- BREQ state: be_req_tvalid = 1, be_req_tdata = latched tag. On be_req_tready, deassert and go to FILL.
- FILL state:
  - be_rsp_tready = 1. Each beat is written into the fill buffer at slice [k*BEAT_WIDTH +: BEAT_WIDTH], k = beat index 0..BEATS-1, first beat in the LSBs.
  - On beat BEATS-1: write the victim line (data, tag, valid = 1), touch it, load the response register, set fe_rsp_tuser = 0, go to RSP.
  - If be_rsp_tlast does not equal (k == BEATS-1), set err; err stays set until reset. Completion always follows the beat count.
- RSP state: fe_rsp_tvalid = 1 until fe_rsp_tready, then go to IDLE. fe_req_tready = 0 in BREQ, FILL and RSP; only one request is outstanding at a time.
- Victim selection: the lowest-index line with valid = 0; if all lines are valid, the line with age = CACHE_DEPTH-1.
- Touch of line k:
  - Every line with age < age[k] increments; age[k] becomes 0.
  - Ages stay a permutation of 0..CACHE_DEPTH-1 with width clog2(CACHE_DEPTH).
- Flush:
  - Asserted in IDLE: clears all valid bits that cycle and fe_req_tready = 0 that cycle. Ages are unchanged.
  - Asserted in any other state: latched as pending and applied on the first IDLE cycle, before any accept. An in-flight fill still completes and returns its data; the flush then invalidates it.
- Counters saturate at all-ones.
- Reset mid-fill: everything returns to reset values immediately. Backend beats still in flight are not accepted (be_rsp_tready = 0).

Test Plan (CACHE_DEPTH=4, LINE_WIDTH=512, BEAT_WIDTH=128, BEATS=4 unless stated):
- Cold miss: request tag 0x100; backend beats 0xA0..0xA3 with tlast on the 4th → one be_req with tdata 0x100; fe_rsp_tdata = {A3,A2,A1,A0}; tuser = 0; miss_cnt = 1.
- Hit: repeat tag 0x100 → no be_req; fe_rsp_tvalid asserted 1 cycle after accept; same data; tuser = 1; hit_cnt = 1.
- Fill, reuse, evict:
  - Fill tags 1,2,3,4 (lines 0..3 in order), then hit 1, then request 5 → victim is tag 2's line.
  - Then request 2 → miss; tag 1 still hits.
- Flush: after 4 fills, pulse flush in IDLE → next requests for all 4 tags miss; fills go to lines 0,1,2,3 in order.
- Flush and tlast errors:
  - Flush during FILL → the response is still delivered; the following same-tag request misses.
  - tlast on beat 2 → err = 1 sticky; fill still takes 4 beats.
- Backpressure and reset:
  - Hold fe_rsp_tready = 0 for 5 cycles → tdata and tuser stable; fe_req_tready = 0 throughout.
  - rstn low mid-FILL → all outputs at reset values at once, asynchronously.
